// File: rtl/rr_arb2_mux_if.sv
// rr_arb2_mux_if: valid/ready bundle for the two producers, the consumer and the mux select
interface rr_arb2_mux_if #(
    parameter int W = 8
);
    logic         d0_valid;
    logic [W-1:0] d0_data;
    logic         d0_ready;
    logic         d1_valid;
    logic [W-1:0] d1_data;
    logic         d1_ready;
    logic         sel;
    logic         y_valid;
    logic [W-1:0] y_data;
    logic         y_src;
    logic         y_ready;
    modport master (
        input  d0_valid, d0_data, d1_valid, d1_data, y_ready,
        output d0_ready, d1_ready, sel, y_valid, y_data, y_src
    );
    modport slave (
        output d0_valid, d0_data, d1_valid, d1_data, y_ready,
        input  d0_ready, d1_ready, sel, y_valid, y_data, y_src
    );
endinterface

// File: rtl/rr_arb2_mux.sv
// rr_arb2_mux: fair two-source round-robin arbiter feeding a one-entry output buffer and a 2:1 mux select
module rr_arb2_mux #(
    parameter int W = 8
) (
    input logic           clk,
    input logic           rst_n,
    rr_arb2_mux_if.master bus
);
    logic         prio;
    logic         sel_q;
    logic         any;
    logic         gnt;
    logic         load_en;
    logic         xfer;
    logic         y_valid;
    logic         y_src;
    logic [W-1:0] y_data;
    // Grant and handshake stay combinational so y_ready reaches the producers in the same cycle; ready is held low in reset
    always_comb begin
        any          = bus.d0_valid || bus.d1_valid;
        gnt          = (bus.d0_valid && bus.d1_valid) ? prio : bus.d1_valid;
        load_en      = !y_valid || bus.y_ready;
        bus.d0_ready = rst_n && load_en && bus.d0_valid && !gnt;
        bus.d1_ready = rst_n && load_en && bus.d1_valid && gnt;
        xfer         = bus.d0_ready || bus.d1_ready;
        bus.sel      = any ? gnt : sel_q;
    end
    // Buffer loads on a transfer (replacing a word draining in the same cycle), empties on a bare drain; prio flips only on transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= 1'b0;
            sel_q   <= 1'b0;
            y_valid <= 1'b0;
            y_src   <= 1'b0;
            y_data  <= '0;
        end else begin
            if (any) sel_q <= gnt;
            if (xfer) begin
                y_valid <= 1'b1;
                y_src   <= gnt;
                y_data  <= gnt ? bus.d1_data : bus.d0_data;
                prio    <= !gnt;
            end else if (bus.y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end
    assign bus.y_valid = y_valid;
    assign bus.y_src   = y_src;
    assign bus.y_data  = y_data;
endmodule

// File: tb/tb_rr_arb2_mux.sv
// tb_rr_arb2_mux: directed and random checks of the round-robin arbiter against a behavioural model and scoreboard
module tb_rr_arb2_mux;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rr_arb2_mux_if #(.W(W)) bus ();
    rr_arb2_mux #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_chk = 0;
    int n_pass = 0;
    bit m_prio, m_yv, m_ys, m_sel, m_g, m_tk;
    logic [W-1:0] m_yd;
    logic [W:0] sb[$];
    logic [W:0] front;
    int w0, w1;
    bit a0, a1;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask
    // who wins this cycle: the lone requester, or the favoured one on contention
    function automatic bit win();
        return (bus.d0_valid && bus.d1_valid) ? m_prio : bus.d1_valid;
    endfunction
    // source x may hand over a word when it requests, wins, and the buffer is free or draining
    function automatic bit er(bit x);
        return rst_n && (!m_yv || bus.y_ready) && (x ? bus.d1_valid : bus.d0_valid) && (win() == x);
    endfunction
    // model state advances on each edge from the inputs seen at that edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prio = 0; m_yv = 0; m_ys = 0; m_sel = 0; m_yd = '0;
        end else begin
            m_g  = win();
            m_tk = er(0) || er(1);
            if (bus.d0_valid || bus.d1_valid) m_sel = m_g;
            if (m_tk) begin
                m_yv = 1; m_ys = m_g; m_yd = m_g ? bus.d1_data : bus.d0_data; m_prio = !m_g;
            end else if (bus.y_ready) begin
                m_yv = 0;
            end
        end
    end
    // every cycle: outputs vs model, delivery order scoreboard, fairness
    always @(negedge clk) begin
        chk("y_valid", bus.y_valid, m_yv);
        chk("y_data", bus.y_data, m_yd);
        chk("y_src", bus.y_src, m_ys);
        chk("d0_ready", bus.d0_ready, er(0));
        chk("d1_ready", bus.d1_ready, er(1));
        chk("sel", bus.sel, (bus.d0_valid || bus.d1_valid) ? win() : m_sel);
        chk("onehot", bus.d0_ready && bus.d1_ready, 0);
        if (!rst_n) begin
            sb.delete(); w0 = 0; w1 = 0;
        end else begin
            if (bus.y_valid && bus.y_ready) begin
                chk("sb_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    front = sb.pop_front();
                    chk("sb_word", {bus.y_src, bus.y_data}, front);
                end
            end
            if (bus.d0_valid && bus.d0_ready) sb.push_back({1'b0, bus.d0_data});
            if (bus.d1_valid && bus.d1_ready) sb.push_back({1'b1, bus.d1_data});
            if (bus.d0_valid && bus.d0_ready) w0 = 0;
            else if (bus.d0_valid && bus.d1_ready) begin w0++; chk("fair0", w0 <= 1, 1); end
            if (bus.d1_valid && bus.d1_ready) w1 = 0;
            else if (bus.d1_valid && bus.d0_ready) begin w1++; chk("fair1", w1 <= 1, 1); end
        end
    end
    task automatic step(bit v0, logic [W-1:0] x0, bit v1, logic [W-1:0] x1, bit yr);
        @(posedge clk); #1;
        bus.d0_valid = v0; bus.d0_data = x0; bus.d1_valid = v1; bus.d1_data = x1; bus.y_ready = yr;
        @(negedge clk);
    endtask
    initial begin
        bus.d0_valid = 0; bus.d0_data = '0; bus.d1_valid = 0; bus.d1_data = '0; bus.y_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_yv", bus.y_valid, 0);
        chk("rst_sel", bus.sel, 0);
        @(posedge clk); #1 rst_n = 1;
        // contention alternates starting with D0
        step(1, 8'hA0, 1, 8'hB0, 1); chk("c1_r0", bus.d0_ready, 1); chk("c1_r1", bus.d1_ready, 0); chk("c1_sel", bus.sel, 0);
        step(1, 8'hA1, 1, 8'hB0, 1); chk("c2_y", bus.y_data, 8'hA0); chk("c2_src", bus.y_src, 0); chk("c2_sel", bus.sel, 1);
        step(1, 8'hA1, 1, 8'hB1, 1); chk("c3_y", bus.y_data, 8'hB0); chk("c3_src", bus.y_src, 1); chk("c3_sel", bus.sel, 0);
        step(1, 8'hA2, 1, 8'hB1, 1); chk("c4_y", bus.y_data, 8'hA1); chk("c4_sel", bus.sel, 1);
        step(0, 8'h00, 0, 8'h00, 1); chk("c5_y", bus.y_data, 8'hB1); chk("c5_src", bus.y_src, 1);
        // single source back-to-back
        step(1, 8'h11, 0, 8'h00, 1); chk("s1_r0", bus.d0_ready, 1); chk("s1_yv", bus.y_valid, 0); chk("s1_sel", bus.sel, 0);
        step(1, 8'h22, 0, 8'h00, 1); chk("s2_y", bus.y_data, 8'h11); chk("s2_src", bus.y_src, 0);
        step(1, 8'h33, 0, 8'h00, 1); chk("s3_y", bus.y_data, 8'h22);
        step(0, 8'h00, 0, 8'h00, 1); chk("s4_y", bus.y_data, 8'h33); chk("s4_sel", bus.sel, 0);
        // idle cycles leave priority alone
        step(0, 8'h00, 1, 8'hC1, 1); chk("i1_r1", bus.d1_ready, 1);
        repeat (4) step(0, 8'h00, 0, 8'h00, 1);
        step(1, 8'hD0, 1, 8'hD1, 1); chk("i6_r0", bus.d0_ready, 1); chk("i6_r1", bus.d1_ready, 0); chk("i6_sel", bus.sel, 0);
        step(0, 8'h00, 1, 8'hD1, 1); chk("i7_y", bus.y_data, 8'hD0); chk("i7_r1", bus.d1_ready, 1);
        step(0, 8'h00, 0, 8'h00, 1); chk("i8_y", bus.y_data, 8'hD1); chk("i8_src", bus.y_src, 1);
        // back-pressure holds the word, release loads with no bubble
        step(1, 8'h5A, 0, 8'h00, 0); chk("b1_r0", bus.d0_ready, 1);
        repeat (3) begin
            step(1, 8'h66, 1, 8'h77, 0);
            chk("bp_y", bus.y_data, 8'h5A); chk("bp_r0", bus.d0_ready, 0); chk("bp_r1", bus.d1_ready, 0);
        end
        step(1, 8'h66, 1, 8'h77, 1); chk("b5_r1", bus.d1_ready, 1); chk("b5_r0", bus.d0_ready, 0); chk("b5_y", bus.y_data, 8'h5A);
        step(1, 8'h66, 0, 8'h00, 1); chk("b6_y", bus.y_data, 8'h77); chk("b6_yv", bus.y_valid, 1); chk("b6_r0", bus.d0_ready, 1);
        step(0, 8'h00, 0, 8'h00, 1); chk("b7_y", bus.y_data, 8'h66);
        step(0, 8'h00, 0, 8'h00, 1);
        // reset mid-stream with a buffered word
        step(1, 8'h88, 1, 8'h99, 0); chk("r1_r1", bus.d1_ready, 1);
        step(1, 8'h88, 1, 8'hAA, 0); chk("r2_yv", bus.y_valid, 1); chk("r2_y", bus.y_data, 8'h99);
        @(posedge clk); #1 rst_n = 0; #1;
        chk("ra_yv", bus.y_valid, 0); chk("ra_src", bus.y_src, 0);
        chk("ra_r0", bus.d0_ready, 0); chk("ra_r1", bus.d1_ready, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk); chk("rr_r0", bus.d0_ready, 1); chk("rr_r1", bus.d1_ready, 0); chk("rr_sel", bus.sel, 0);
        step(0, 8'h00, 1, 8'hAA, 1); chk("rr_y", bus.y_data, 8'h88); chk("rr_r1b", bus.d1_ready, 1);
        step(0, 8'h00, 0, 8'h00, 1); chk("rr_y2", bus.y_data, 8'hAA);
        // random traffic; producers hold a word until it is taken
        for (int i = 0; i < 10000; i++) begin
            a0 = bus.d0_valid && bus.d0_ready;
            a1 = bus.d1_valid && bus.d1_ready;
            @(posedge clk); #1;
            if (!bus.d0_valid || a0) begin
                bus.d0_valid = $urandom_range(0, 9) < 7;
                bus.d0_data = W'($urandom);
            end
            if (!bus.d1_valid || a1) begin
                bus.d1_valid = $urandom_range(0, 9) < 7;
                bus.d1_data = W'($urandom);
            end
            bus.y_ready = $urandom_range(0, 9) < 6;
            @(negedge clk);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rr_arb2_mux.md
# rr_arb2_mux

Two-input round-robin stream arbiter that produces the select for a 2:1 mux and registers the chosen word into a single-entry output buffer. It sits directly upstream of the team's 2:1 multiplexer (`mux21_*` family) and drives its `S` input. Two independent valid/ready producers feed it, and one valid/ready consumer drains it. Arbitration is fair, throughput is one word per cycle, and latency is one cycle.

## Interface
- `W`, default 8: data width of both inputs and the output.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronous to `clk` by the integrator.
- `d0_valid` input 1: source 0 has a word.
- `d0_data` input W: source 0 word.
- `d0_ready` output 1: source 0 word accepted this cycle.
- `d1_valid` input 1: source 1 has a word.
- `d1_data` input W: source 1 word.
- `d1_ready` output 1: source 1 word accepted this cycle.
- `sel` output 1: mux select (0 = D0, 1 = D1). Same encoding as the mux `S`.
- `y_valid` output 1: output buffer holds a word.
- `y_data` output W: buffered word.
- `y_src` output 1: source index of the buffered word.
- `y_ready` input 1: consumer accepts the word this cycle.

## Operation
- State:
  - output buffer (`y_valid`, `y_data`, `y_src`);
  - priority flag `prio`: the source favoured on contention.
- `load_en = !y_valid || y_ready`. The buffer can take a new word this cycle.
- Grant (combinational):
  - neither valid: no grant; `sel` holds its previous registered value.
  - only D0 valid: grant D0.
  - only D1 valid: grant D1.
  - both valid: grant `prio`.
- `sel` = granted index when a grant exists.
- `dX_ready = load_en && grant==X`. At most one ready per cycle; never asserted for a non-valid source.
- Transfer on a source occurs when `dX_valid && dX_ready`. On that edge:
  - `y_data` ← `dX_data`;
  - `y_src` ← X;
  - `y_valid` ← 1;
  - `prio` ← ~X.
- Drain without a new load (`y_valid && y_ready`, no grant): `y_valid` ← 0. `y_data` and `y_src` hold their values.
- Simultaneous drain and load: the new word replaces the old one; `y_valid` stays 1. No bubble.
- Back-pressure (`y_valid && !y_ready`):
  - `y_data` and `y_src` are held stable;
  - both readies are 0;
  - `prio` is unchanged.
- Fairness: a continuously valid source waits at most one transfer of the other source.
- `prio` changes only on a transfer. Idle cycles never change it.
- Reset mid-operation: a buffered word is discarded and the in-flight handshake is abandoned. Producers must re-present their data.

## Timing
- Reset values:
  - `y_valid` = 0, `y_data` = 0, `y_src` = 0;
  - `prio` = 0 (D0 favoured first);
  - registered `sel` = 0;
  - `d0_ready` = `d1_ready` = 0 while `rst_n` = 0.
- Latency: a word accepted at edge N is visible on `y_data` with `y_valid` = 1 after edge N, in cycle N+1.
- Throughput: 1 word/cycle when `y_ready` is held at 1.
- Combinational paths:
  - `y_ready` → `dX_ready`;
  - `dX_valid` → `sel` and `dX_ready`.
  - No combinational path from any input to `y_valid`, `y_data` or `y_src`.
- Producer rule: once `dX_valid` = 1, the producer must hold `dX_valid` and `dX_data` until `dX_ready` = 1. The arbiter may rely on this.
- Consumer rule: `y_ready` may toggle freely. `y_ready` = 1 while `y_valid` = 0 has no effect.

## Test plan
- Reset: drive `rst_n` = 0 mid-stream with `y_valid` = 1. Required: `y_valid` = 0, `y_src` = 0, both readies = 0 immediately. First contended grant after release goes to D0.
- Single source: D0 sends 0x11, 0x22, 0x33 back-to-back with `y_ready` = 1. Required:
  - `y_data` = 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after acceptance;
  - `y_src` = 0 throughout;
  - `sel` = 0.
- Contention: both valid continuously, D0 = 0xA0.., D1 = 0xB0.., `y_ready` = 1. Required:
  - `y_src` alternates 0,1,0,1;
  - `y_data` = 0xA0, 0xB0, 0xA1, 0xB1;
  - `sel` alternates in step.
- Back-pressure: buffer full with 0x5A, `y_ready` = 0 for 3 cycles, both sources valid. Required:
  - `y_data` = 0x5A held;
  - both readies = 0;
  - `prio` unchanged;
  - on release, the favoured source loads in the same cycle as the drain, with no bubble.
- Idle priority: transfer from D1, then 4 idle cycles, then both valid. Required: D0 granted first, because `prio` was not changed by the idle cycles.
- Random: 10k cycles of random valids, random `y_ready` and `W` = 8. Scoreboard checks per source:
  - in-order delivery, no loss, no duplication;
  - readies never one-hot violated;
  - maximum wait of one competing transfer.
